// File: rtl/uart_pkg.sv
// Shared UART state numbering and parity constants for the TX and RX FSMs.
// STOP2 joins the TX state type only when UART_TX_TWO_STOP_EN is defined.
package uart_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = S_IDLE,
    START  = S_START,
    DATA   = S_DATA,
    PARITY = S_PARITY,
`ifdef UART_TX_TWO_STOP_EN
    STOP2  = S_STOP2,
`endif
    STOP   = S_STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit edge counter and frame bit counter for the UART transmitter.
// bit_done is combinational in the last clock of each bit; restart zeroes both counters.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PWIDTH = 6,
  parameter int DWIDTH = 8,
  parameter int BW     = (DWIDTH > 1) ? $clog2(DWIDTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWIDTH-1:0] prescale_q,
  input  logic              run,
  input  logic              restart,
  output logic              bit_done,
  output logic [BW-1:0]     bit_cnt
);

  logic [PWIDTH-1:0] edge_cnt_q, edge_cnt_d;
  logic [PWIDTH-1:0] last_edge;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;

  always_comb begin
    // prescale 0 wraps to all-ones, giving 2^PWIDTH clocks per bit
    last_edge  = prescale_q - PWIDTH'(1);
    bit_done   = run && (edge_cnt_q == last_edge);
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    if (restart) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_done) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + BW'(1);
    end else if (run) begin
      edge_cnt_d = edge_cnt_q + PWIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  assign bit_cnt = bit_cnt_q;

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start, DWIDTH data bits LSB-first, optional parity, stop (two with UART_TX_TWO_STOP_EN).
// Start bit appears one clock after accept; ready only in IDLE or the final stop-bit clock, allowing back-to-back frames.
module uart_tx_fsm
  import uart_pkg::*;
#(
  parameter int PWIDTH = 6,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PWIDTH-1:0] prescale,
  input  logic [DWIDTH-1:0] p_data,
  input  logic              data_valid,
  input  logic              parity_en,
  input  logic              parity_type,
  output logic              ready,
  output logic              busy,
  output logic              tx_out
);

  localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DWIDTH - 1);
`ifdef UART_TX_TWO_STOP_EN
  localparam tx_state_e LAST_STOP = STOP2;
`else
  localparam tx_state_e LAST_STOP = STOP;
`endif

  tx_state_e         state_q, state_d;
  logic              tx_out_q, tx_out_d;
  logic              busy_q, busy_d;
  logic [DWIDTH-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              par_en_q, par_en_d;
  logic [PWIDTH-1:0] prescale_q, prescale_d;
  logic              bit_done, restart, accept, run;
  logic [BW-1:0]     bit_cnt;

  uart_tx_bit_timer #(.PWIDTH(PWIDTH), .DWIDTH(DWIDTH), .BW(BW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .prescale_q (prescale_q),
    .run        (run),
    .restart    (restart),
    .bit_done   (bit_done),
    .bit_cnt    (bit_cnt)
  );

  always_comb begin
    run        = (state_q != IDLE);
    ready      = (state_q == IDLE) || ((state_q == LAST_STOP) && bit_done);
    accept     = data_valid && ready;
    state_d    = state_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    par_en_d   = par_en_q;
    prescale_d = prescale_q;
    restart    = 1'b0;
    if (accept) begin
      state_d    = START;
      shift_d    = p_data;
      par_en_d   = parity_en;
      prescale_d = prescale;
      restart    = 1'b1;
      case (parity_type)
        PAR_ODD:  parity_d = ~^p_data;
        default:  parity_d = ^p_data;
      endcase
    end else begin
      case (state_q)
        IDLE: ;
        START: if (bit_done) begin
          state_d = DATA;
          restart = 1'b1;
        end
        DATA: if (bit_done) begin
          if (bit_cnt == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
          else                     shift_d = shift_q >> 1;
        end
        PARITY: if (bit_done) state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
        STOP:  if (bit_done) state_d = STOP2;
        STOP2: if (bit_done) state_d = IDLE;
`else
        STOP:  if (bit_done) state_d = IDLE;
`endif
        default: state_d = IDLE;
      endcase
    end

    // line level is decoded from the next state so tx_out stays a clean flop
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      PARITY:  tx_out_d = parity_q;
      default: tx_out_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      par_en_q   <= 1'b0;
      prescale_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      par_en_q   <= par_en_d;
      prescale_q <= prescale_d;
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: the driver queues expected frames at accept,
// a line monitor decodes each frame from tx_out and checks it bit by bit.
module tb_uart_tx_fsm;

  localparam int PW = 6;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] prescale = '0;
  logic [DW-1:0] p_data = '0;
  logic          data_valid = 1'b0;
  logic          parity_en = 1'b0;
  logic          parity_type = 1'b0;
  logic          ready, busy, tx_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] d;
    int         p;
    bit         pe;
    bit         pt;
    longint     t;
  } exp_t;

  exp_t exp_q[$];

  uart_tx_fsm #(.PWIDTH(PW), .DWIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .prescale    (prescale),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .parity_en   (parity_en),
    .parity_type (parity_type),
    .ready       (ready),
    .busy        (busy),
    .tx_out      (tx_out)
  );

  always #5 clk = ~clk;

  // Drive a byte and hold data_valid until the DUT is ready; returns at the start-bit negedge.
  task automatic send(input logic [7:0] d, input int p, input bit pe, input bit pt);
    exp_t e;
    int   n;
    p_data      = d;
    prescale    = PW'(p);
    parity_en   = pe;
    parity_type = pt;
    data_valid  = 1'b1;
    n = 0;
    while (!ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready ready=%0b after %0d cycles, required 1", ready, n);
      data_valid = 1'b0;
      return;
    end
    e.d = d; e.p = p; e.pe = pe; e.pt = pt;
    e.t = longint'($time) + 10;
    exp_q.push_back(e);
    @(negedge clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || busy) && n < 3000);
    if (exp_q.size() != 0 || busy) begin
      checks++;
      errors++;
      $display("FAIL wait_done queued=%0d busy=%0b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  // Decode one frame; called at the negedge where the start bit is first seen.
  task automatic check_frame();
    exp_t e;
    logic b[0:12];
    int   nb, p, ones;
    bit   bad, exp_rdy;
    logic got_tx, got_busy, got_rdy;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_start tx_out fell at %0t with no frame queued", $time);
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (longint'($time) != e.t) begin
      errors++;
      $display("FAIL start_time start bit at %0t, required %0d", $time, e.t);
    end
    ones = $countones(e.d);
    nb = 0;
    b[nb++] = 1'b0;
    for (int i = 0; i < DW; i++) b[nb++] = e.d[i];
    if (e.pe) b[nb++] = e.pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
    b[nb++] = 1'b1;
`ifdef UART_TX_TWO_STOP_EN
    b[nb++] = 1'b1;
`endif
    p = (e.p == 0) ? 64 : e.p;
    for (int k = 0; k < nb; k++) begin
      bad = 0;
      got_tx = 1'b0; got_busy = 1'b0; got_rdy = 1'b0; exp_rdy = 0;
      for (int j = 0; j < p; j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        if (!rst) return;
        exp_rdy = (k == nb - 1) && (j == p - 1);
        if (!bad && (tx_out !== b[k] || busy !== 1'b1 || ready !== exp_rdy)) begin
          bad = 1;
          got_tx = tx_out; got_busy = busy; got_rdy = ready;
        end
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL frame_bit data=%02h bit %0d got tx/busy/ready=%0b/%0b/%0b, required %0b/1/(last clock only)",
                 e.d, k, got_tx, got_busy, got_rdy, b[k]);
      end
    end
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev = 1'b1;
      end else begin
        if (prev && !tx_out) begin
          check_frame();
        end else begin
          checks++;
          if (tx_out !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_line tx/busy/ready=%0b/%0b/%0b at %0t, required 1/0/1",
                     tx_out, busy, ready, $time);
          end
        end
        prev = tx_out;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL %s tx/busy/ready=%0b/%0b/%0b, required 1/0/1", tag, tx_out, busy, ready);
    end
  endtask

  initial begin : stimulus
    #1 rst = 1'b0;
    #2 check_reset_outputs("reset_state");
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);

    send(8'hA5, 8, 0, 0);
    wait_done();
    send(8'h03, 16, 1, 0);
    wait_done();
    send(8'h03, 16, 1, 1);
    wait_done();

    send(8'h00, 8, 0, 0);
    send(8'hFF, 8, 0, 0);
    wait_done();

    send(8'h3C, 10, 1, 1);
    repeat (40) begin
      @(negedge clk);
      p_data      = 8'($urandom);
      prescale    = PW'($urandom_range(4, 63));
      parity_en   = 1'($urandom);
      parity_type = 1'($urandom);
    end
    wait_done();
    repeat (100) @(negedge clk);

    send(8'h55, 8, 0, 0);
    #352 rst = 1'b0;
    #1 check_reset_outputs("reset_mid_frame");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    send(8'h55, 8, 0, 0);
    wait_done();

    send(8'($urandom), 0, 1, 0);
    wait_done();

    for (int i = 0; i < 25; i++) begin
      send(8'($urandom), $urandom_range(4, 40), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
        repeat ($urandom_range(0, 6)) @(negedge clk);
      end
    end
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
